// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   state_e   : FSM encoding (IDLE, CALC, FIX)
//   OP_MUL/OP_DIV : encoding of the op_div request bit
//   DEF_WIDTH : default operand / HI / LO width
package muldiv_pkg;

   localparam int   DEF_WIDTH = 32;
   localparam logic OP_MUL    = 1'b0;
   localparam logic OP_DIV    = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the control datapath and muldiv_unit.
//   master : start, op_div, op_signed, src_a, src_b driven; busy, done, div_zero, hi, lo observed
//   slave  : the opposite direction, used by muldiv_unit
// Optional macro MULDIV_MTHILO_EN adds hi_we, lo_we, wdata (MTHI/MTLO writes).
interface muldiv_if import muldiv_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic             op_div;
   logic             op_signed;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MULDIV_MTHILO_EN
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;

   modport master (output start, op_div, op_signed, src_a, src_b, hi_we, lo_we, wdata,
                   input  busy, done, div_zero, hi, lo);
   modport slave  (input  start, op_div, op_signed, src_a, src_b, hi_we, lo_we, wdata,
                   output busy, done, div_zero, hi, lo);
`else
   modport master (output start, op_div, op_signed, src_a, src_b,
                   input  busy, done, div_zero, hi, lo);
   modport slave  (input  start, op_div, op_signed, src_a, src_b,
                   output busy, done, div_zero, hi, lo);
`endif

endinterface

// File: rtl/muldiv_abs.sv
// muldiv_abs: conditional two's-complement negate (combinational).
//   neg  : 1 = output -din, 0 = pass din through
//   din  : WIDTH-bit input
//   dout : WIDTH-bit result (most-negative input maps to itself, which read
//          unsigned is exactly its magnitude)
module muldiv_abs #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with HI/LO result registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : muldiv_if.slave -- start/op_div/op_signed/src_a/src_b in,
//           busy/done/div_zero/hi/lo out
// Multiply is radix-2 shift-add, divide is restoring shift-subtract, both on
// operand magnitudes with one iteration per cycle; signs are applied in FIX.
// Optional macro MULDIV_MTHILO_EN enables direct HI/LO writes while idle.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH+1);
   localparam int W2    = 2*WIDTH;

   state_e             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               op_r, op_n;
   logic               sgn_a, sgn_a_n;
   logic               sgn_b, sgn_b_n;
   logic               dz_pend, dz_pend_n;
   logic [WIDTH-1:0]   mcand, mcand_n;
   // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [W2-1:0]      acc, acc_n;
   logic               busy_r, busy_n;
   logic               done_r, done_n;
   logic               dz_r, dz_n;
   logic [WIDTH-1:0]   hi_r, hi_n;
   logic [WIDTH-1:0]   lo_r, lo_n;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH:0]     mul_sum;
   logic [W2-1:0]      mul_next;
   logic [WIDTH:0]     div_sh, div_diff;
   logic               div_ge;
   logic [W2-1:0]      div_next;
   logic [W2-1:0]      prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign acc_hi = acc[W2-1:WIDTH];
   assign acc_lo = acc[WIDTH-1:0];

   // operand magnitudes
   muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
      .neg (bus.op_signed & bus.src_a[WIDTH-1]),
      .din (bus.src_a),
      .dout(mag_a)
   );
   muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
      .neg (bus.op_signed & bus.src_b[WIDTH-1]),
      .din (bus.src_b),
      .dout(mag_b)
   );

   // multiply step: add multiplicand if LSB of multiplier set, shift right
   assign mul_sum  = {1'b0, acc_hi} + (acc[0] ? {1'b0, mcand} : '0);
   assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

   // divide step: shift next dividend bit into remainder, trial subtract.
   // Remainder stays below the divisor, so div_sh < 2*divisor and a
   // non-negative difference always has MSB clear: the MSB is the borrow.
   assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, mcand};
   assign div_ge   = ~div_diff[WIDTH];
   assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                      acc_lo[WIDTH-2:0], div_ge};

   // sign correction
   muldiv_abs #(.WIDTH(W2)) u_fix_prod (
      .neg (sgn_a ^ sgn_b),
      .din (acc),
      .dout(prod_fix)
   );
   muldiv_abs #(.WIDTH(WIDTH)) u_fix_quo (
      .neg (sgn_a ^ sgn_b),
      .din (acc_lo),
      .dout(quo_fix)
   );
   muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (
      .neg (sgn_a),
      .din (acc_hi),
      .dout(rem_fix)
   );

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      op_n      = op_r;
      sgn_a_n   = sgn_a;
      sgn_b_n   = sgn_b;
      dz_pend_n = dz_pend;
      mcand_n   = mcand;
      acc_n     = acc;
      busy_n    = busy_r;
      done_n    = 1'b0;
      dz_n      = 1'b0;
      hi_n      = hi_r;
      lo_n      = lo_r;
      case (state)
         IDLE: begin
            if (bus.start) begin
               op_n      = bus.op_div;
               sgn_a_n   = bus.op_signed & bus.src_a[WIDTH-1];
               sgn_b_n   = bus.op_signed & bus.src_b[WIDTH-1];
               mcand_n   = mag_b;
               acc_n     = {{WIDTH{1'b0}}, mag_a};
               cnt_n     = CNT_W'(WIDTH);
               busy_n    = 1'b1;
               dz_pend_n = (bus.op_div == OP_DIV) && (bus.src_b == '0);
               state_n   = dz_pend_n ? FIX : CALC;
            end
`ifdef MULDIV_MTHILO_EN
            else begin
               if (bus.hi_we) hi_n = bus.wdata;
               if (bus.lo_we) lo_n = bus.wdata;
            end
`endif
         end
         CALC: begin
            acc_n = (op_r == OP_DIV) ? div_next : mul_next;
            cnt_n = cnt - 1'b1;
            if (cnt == CNT_W'(1)) state_n = FIX;
         end
         FIX: begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
            if (dz_pend) begin
               dz_n = 1'b1;
            end else if (op_r == OP_DIV) begin
               hi_n = rem_fix;
               lo_n = quo_fix;
            end else begin
               {hi_n, lo_n} = prod_fix;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_r    <= 1'b0;
         sgn_a   <= 1'b0;
         sgn_b   <= 1'b0;
         dz_pend <= 1'b0;
         mcand   <= '0;
         acc     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dz_r    <= 1'b0;
         hi_r    <= '0;
         lo_r    <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         op_r    <= op_n;
         sgn_a   <= sgn_a_n;
         sgn_b   <= sgn_b_n;
         dz_pend <= dz_pend_n;
         mcand   <= mcand_n;
         acc     <= acc_n;
         busy_r  <= busy_n;
         done_r  <= done_n;
         dz_r    <= dz_n;
         hi_r    <= hi_n;
         lo_r    <= lo_n;
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = dz_r;
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized check of muldiv_unit (WIDTH=32)
// against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   errs = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: plain 64-bit arithmetic, C-style truncating signed division
   task automatic model(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic dz);
      longint sa, sb, sp, sq, sr;
      logic [63:0] up;
      dz = 1'b0;
      h  = exp_hi;
      l  = exp_lo;
      sa = $signed(a);
      sb = $signed(b);
      if (!d) begin
         if (s) begin
            sp = sa * sb;
            {h, l} = sp;
         end else begin
            up = {32'b0, a} * {32'b0, b};
            {h, l} = up;
         end
      end else if (b == 0) begin
         dz = 1'b1;
      end else if (s) begin
         sq = sa / sb;
         sr = sa % sb;
         l = sq[31:0];
         h = sr[31:0];
      end else begin
         l = a / b;
         h = a % b;
      end
   endtask

   // poke=1 fires a second start mid-CALC, which must be ignored
   task automatic run_op(input string tag, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input bit poke);
      logic [31:0] h, l;
      logic dz;
      int k;
      model(d, s, a, b, h, l, dz);
      @(negedge clk);
      bus.start = 1'b1; bus.op_div = d; bus.op_signed = s; bus.src_a = a; bus.src_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op_div = ~d; bus.op_signed = ~s;
      bus.src_a = $urandom; bus.src_b = $urandom;
      check({tag, ":busy_acc"}, bus.busy, 1);
      check({tag, ":done_clr"}, {bus.done, bus.div_zero}, 0);
      k = 0;
      while (!bus.done && k < 40) begin
         @(posedge clk); #1;
         k++;
         if (k == 3 && poke) begin
            bus.start = 1'b1; bus.src_a = $urandom; bus.src_b = $urandom;
         end
         if (k == 4) bus.start = 1'b0;
         if (k == 5 && !bus.done) begin
            check({tag, ":busy_mid"}, bus.busy, 1);
            check({tag, ":hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
         end
      end
      check({tag, ":latency"}, k, dz ? 1 : 33);
      check({tag, ":hi"}, bus.hi, h);
      check({tag, ":lo"}, bus.lo, l);
      check({tag, ":dz"}, bus.div_zero, dz);
      check({tag, ":busy_end"}, bus.busy, 0);
      exp_hi = h;
      exp_lo = l;
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h0;
         1: v = 32'h1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int n;
      bus.start = 1'b0; bus.op_div = 1'b0; bus.op_signed = 1'b0;
      bus.src_a = '0; bus.src_b = '0;
`ifdef MULDIV_MTHILO_EN
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst:busy", bus.busy, 0);
      check("rst:done", bus.done, 0);
      check("rst:dz", bus.div_zero, 0);
      check("rst:hi", bus.hi, 0);
      check("rst:lo", bus.lo, 0);
      @(negedge clk);
      reset = 1'b1;

      run_op("smul", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
      check("smul_val", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("umul", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("umul_val", {exp_hi, exp_lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("sdiv_val", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("ovf_val", {exp_hi, exp_lo}, 64'h0000_0000_8000_0000);
      // preload hi/lo = 0x11/0x22 via 0x451 / 0x20
      run_op("pre", 1'b1, 1'b0, 32'h451, 32'h20, 1'b0);
      check("pre_val", {exp_hi, exp_lo}, 64'h0000_0011_0000_0022);
      run_op("dz", 1'b1, 1'b1, 32'h1234, 32'h0, 1'b0);
      check("dz_val", {exp_hi, exp_lo}, 64'h0000_0011_0000_0022);
      run_op("poke", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);

`ifdef MULDIV_MTHILO_EN
      @(negedge clk);
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      check("mthilo", {bus.hi, bus.lo}, 64'h5555_AAAA_5555_AAAA);
      exp_hi = 32'h5555_AAAA;
      exp_lo = 32'h5555_AAAA;
`endif

      // abort: reset in cycle 10 of CALC
      @(negedge clk);
      bus.start = 1'b1; bus.op_div = 1'b0; bus.op_signed = 1'b0;
      bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort:busy", bus.busy, 0);
      check("abort:hilo", {bus.hi, bus.lo}, 0);
      check("abort:done", bus.done, 0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) n++;
      end
      check("abort:no_done", n, 0);
      run_op("post", 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h10, 1'b0);

      for (int i = 0; i < 40; i++)
         run_op("rnd", 1'($urandom), 1'($urandom), pick(), pick(), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
